fifo_rd_stream: RTL

//  Read-side drain engine for a non-FWFT synchronous FIFO (1-cycle registered RAM read).

---
 rtl/fifo_rd_stream.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side drain engine: non-FWFT FIFO to valid/ready stream via skid buffer
// Optional beat counter enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  flushing,
    output logic                  proto_err,
    output logic [31:0]           beat_cnt
);

    localparam int PTR_W = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic                  proto_err_q, proto_err_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
    logic                  capture;
    logic                  pop;

    // Non-power-of-2 depths need an explicit wrap compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        proto_err_d = proto_err_q;
        buf_d       = buf_q;

        // Reserve a slot for every beat already in flight so the skid never overflows.
        fifo_rd_en = (state_q == ST_RUN) & ~fifo_empty & ~flush &
                     (({1'b0, occ_q} + (OCC_W + 1)'(inflight_q)) < DEPTH_EXT);
        inflight_d = fifo_rd_en;

        m_valid  = (occ_q != '0) & (state_q == ST_RUN);
        m_data   = buf_q[rptr_q];
        flushing = (state_q == ST_FLUSH);

        capture = fifo_valid & inflight_q & (state_q == ST_RUN);
        pop     = m_valid & m_ready;

        if (fifo_valid & ~inflight_q) begin
            proto_err_d = 1'b1;
        end

        if (capture) begin
            buf_d[wptr_q] = fifo_dout;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end

        case ({capture, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    occ_d  = '0;
                    wptr_d = '0;
                    rptr_d = '0;
                    if (inflight_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            proto_err_q <= proto_err_d;
            buf_q       <= buf_d;
        end
    end

    assign proto_err = proto_err_q;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;

    // Saturating count of accepted beats; flush does not clear it.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop && (beat_cnt_q != 32'hFFFF_FFFF)) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`else
    assign beat_cnt = 32'd0;
`endif

endmodule
